// File: rtl/gt_icache_ctrl_if.sv
// Fetch-side and fill-side signals of the instruction cache controller.
// Handshakes: the IFU advances its address counter at a rising clock edge only
// while ctr_en is high. mem_req is a level held until the edge where mem_ack
// is seen high; mem_ack is ignored whenever mem_req is low.
interface gt_icache_ctrl_if;
  logic [31:0] inst_addr;
  logic        addr_valid;
  logic        ctr_en;
  logic        hit;
  logic        miss;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Cache controller side.
  modport slave (
    input  inst_addr, addr_valid, mem_ack,
    output ctr_en, hit, miss, mem_req, mem_addr, hit_count, miss_count
  );

  // IFU / memory / bench side.
  modport master (
    output inst_addr, addr_valid, mem_ack,
    input  ctr_en, hit, miss, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/gt_icache_ctrl.sv
// Direct-mapped instruction-cache tag controller.
// Looks up the fetch address and stalls the IFU on a miss. Each miss is
// serviced by a req/ack block fill that installs the tag. Hits and misses
// are counted with saturating counters.
module gt_icache_ctrl #(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 4,
  parameter int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS
) (
  input  logic                GCLK,
  input  logic                CLEAR,
  gt_icache_ctrl_if.slave     bus,
  output logic [1:0]          o_dbg_state
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REQ    = 2'd1,
    S_RESUME = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag [SETS];

  logic                r_hit;
  logic                r_miss;
  logic                r_mem_req;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_hit_count;
  logic [31:0]         r_miss_count;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_lookup;
  logic                  w_ctr_en;
  logic                  w_hit_ev;
  logic                  w_miss_ev;
  logic                  w_fill;
  logic                  w_unused;

  // Address field split for the live fetch address and the captured fill address.
  assign w_index      = bus.inst_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_tag        = bus.inst_addr[31 -: TAG_BITS];
  assign w_fill_index = r_mem_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_fill_tag   = r_mem_addr[31 -: TAG_BITS];
  assign w_lookup     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused     = ^bus.inst_addr[OFFSET_BITS-1:0];

  // State register; reset abandons any fill in progress.
  always_ff @(posedge GCLK or posedge CLEAR) begin
    if (CLEAR) r_state <= S_LOOKUP;
    else       r_state <= w_next_state;
  end

  // Next-state logic: a miss waits in REQ for ack, then spends one cycle in RESUME.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOOKUP: if (bus.addr_valid && !w_lookup) w_next_state = S_REQ;
      S_REQ:    if (bus.mem_ack)                 w_next_state = S_RESUME;
      S_RESUME: w_next_state = S_LOOKUP;
      default:  w_next_state = S_LOOKUP;
    endcase
  end

  // Output/event decode: ctr_en is Mealy on a hit, and forced high in RESUME.
  always_comb begin
    w_ctr_en  = 1'b0;
    w_hit_ev  = 1'b0;
    w_miss_ev = 1'b0;
    w_fill    = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        w_hit_ev  = bus.addr_valid && w_lookup;
        w_miss_ev = bus.addr_valid && !w_lookup;
        w_ctr_en  = w_hit_ev;
      end
      S_REQ:    w_fill   = bus.mem_ack;
      S_RESUME: w_ctr_en = 1'b1;
      default:  w_ctr_en = 1'b0;
    endcase
  end

  // Valid bits clear on reset; a completed fill marks its set valid.
  always_ff @(posedge GCLK or posedge CLEAR) begin
    if (CLEAR)       r_valid <= '0;
    else if (w_fill) r_valid[w_fill_index] <= 1'b1;
  end

  // Tag storage needs no reset since it is qualified by the valid bit.
  always_ff @(posedge GCLK) begin
    if (w_fill) r_tag[w_fill_index] <= w_fill_tag;
  end

  // Pulses, fill request/address and saturating statistics.
  always_ff @(posedge GCLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_hit  <= w_hit_ev;
      r_miss <= w_miss_ev;
      if (w_miss_ev) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {bus.inst_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end else if (w_fill) begin
        r_mem_req  <= 1'b0;
      end
      if (w_hit_ev && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_miss_ev && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign bus.ctr_en     = w_ctr_en;
  assign bus.hit        = r_hit;
  assign bus.miss       = r_miss;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_gt_icache_ctrl.sv
// Bench for gt_icache_ctrl: directed scenarios plus a randomized fetch stream,
// checked against a set-indexed tag table kept in the bench.
module tb_gt_icache_ctrl;

  logic       GCLK;
  logic       CLEAR;
  logic [1:0] dbg_state;

  gt_icache_ctrl_if bus ();

  gt_icache_ctrl dut (
    .GCLK        (GCLK),
    .CLEAR       (CLEAR),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  logic [31:0] exp_q [$];   // expected fill addresses, in order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / 16) % 16;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_hits   = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    bus.addr_valid = 1'b0;
    #1;
    chk("idle_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
    tick();
    chk("idle_hit", {31'd0, bus.hit}, 32'd0);
    chk("idle_miss", {31'd0, bus.miss}, 32'd0);
  endtask

  // Present one fetch address; on a miss, hold off ack for ack_delay cycles.
  task automatic fetch(input logic [31:0] addr, input int ack_delay, input bit scramble);
    bit          exp_hit;
    logic [31:0] fill_addr;
    exp_hit = m_valid[set_of(addr)] && (m_tag[set_of(addr)] == tag_of(addr));
    bus.inst_addr  = addr;
    bus.addr_valid = 1'b1;
    #1;
    if (exp_hit) begin
      chk("hit_ctr_en", {31'd0, bus.ctr_en}, 32'd1);
      tick();
      m_hits = m_hits + 1;
      chk("hit_pulse", {31'd0, bus.hit}, 32'd1);
      chk("hit_no_miss", {31'd0, bus.miss}, 32'd0);
      chk("hit_count", bus.hit_count, m_hits);
      chk("hit_no_req", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      chk("miss_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
      exp_q.push_back(addr & 32'hFFFF_FFF0);
      tick();
      m_misses = m_misses + 1;
      fill_addr = exp_q.pop_front();
      chk("miss_pulse", {31'd0, bus.miss}, 32'd1);
      chk("miss_no_hit", {31'd0, bus.hit}, 32'd0);
      chk("miss_count", bus.miss_count, m_misses);
      chk("miss_req", {31'd0, bus.mem_req}, 32'd1);
      chk("miss_mem_addr", bus.mem_addr, fill_addr);
      for (int i = 0; i < ack_delay; i++) begin
        if (scramble) begin
          bus.inst_addr  = $urandom;
          bus.addr_valid = 1'($urandom_range(0, 1));
        end
        #1;
        chk("stall_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
        chk("stall_req", {31'd0, bus.mem_req}, 32'd1);
        chk("stall_mem_addr", bus.mem_addr, fill_addr);
        tick();
        chk("stall_no_pulse", {30'd0, bus.hit, bus.miss}, 32'd0);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      m_valid[set_of(fill_addr)] = 1'b1;
      m_tag[set_of(fill_addr)]   = tag_of(fill_addr);
      chk("resume_req_drop", {31'd0, bus.mem_req}, 32'd0);
      chk("resume_ctr_en", {31'd0, bus.ctr_en}, 32'd1);
      tick();
      chk("resume_no_hit", {31'd0, bus.hit}, 32'd0);
      chk("resume_hit_count", bus.hit_count, m_hits);
    end
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    #1;
    model_reset();
    chk("rst_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
    chk("rst_hit", {31'd0, bus.hit}, 32'd0);
    chk("rst_miss", {31'd0, bus.miss}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_hit_count", bus.hit_count, 32'd0);
    chk("rst_miss_count", bus.miss_count, 32'd0);
    tick();
    CLEAR = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] thrash [5];
    logic [31:0] a;
    thrash[0] = 32'h41;
    thrash[1] = 32'h442;
    thrash[2] = 32'hC3;
    thrash[3] = 32'h4042;
    thrash[4] = 32'h43;

    CLEAR          = 1'b1;
    bus.inst_addr  = '0;
    bus.addr_valid = 1'b0;
    bus.mem_ack    = 1'b0;
    model_reset();
    tick();
    tick();
    do_reset();

    // Cold miss acked after 3 cycles, then a hit in the same block.
    fetch(32'h41, 3, 1'b0);
    fetch(32'h43, 0, 1'b0);
    chk("cold_hit_count", bus.hit_count, 32'd1);
    chk("cold_miss_count", bus.miss_count, 32'd1);

    // Conflict thrash: every access misses.
    tick();
    do_reset();
    for (int i = 0; i < 5; i++) fetch(thrash[i], 1, 1'b0);
    chk("thrash_hits", bus.hit_count, 32'd0);
    chk("thrash_misses", bus.miss_count, 32'd5);

    // Throughput: two blocks in different sets, alternating hits one per cycle.
    do_reset();
    fetch(32'h40, 1, 1'b0);
    fetch(32'h850, 1, 1'b0);
    for (int i = 0; i < 8; i++) fetch((i % 2 == 0) ? 32'h41 : 32'h854, 0, 1'b0);
    chk("tput_hits", bus.hit_count, 32'd8);

    // Spurious ack while idle in LOOKUP must not change anything.
    bus.addr_valid = 1'b0;
    bus.mem_ack    = 1'b1;
    tick();
    bus.mem_ack    = 1'b0;
    chk("spur_no_req", {31'd0, bus.mem_req}, 32'd0);
    chk("spur_hits", bus.hit_count, m_hits);
    chk("spur_misses", bus.miss_count, m_misses);
    fetch(32'h41, 0, 1'b0);

    // Long stall with the fetch address wandering during REQ.
    fetch(32'h1230, 20, 1'b1);
    fetch(32'h1234, 0, 1'b0);

    // Reset in the middle of a fill: tag must not be installed.
    bus.inst_addr  = 32'h7770;
    bus.addr_valid = 1'b1;
    tick();
    chk("midfill_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    #2;
    do_reset();
    fetch(32'h7774, 1, 1'b0);
    chk("midfill_remiss", bus.miss_count, 32'd1);
    chk("midfill_hits", bus.hit_count, 32'd0);

    // Randomized stream over a small address space so hits and conflicts mix.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
        fetch(a, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
    end
    chk("rand_hits", bus.hit_count, m_hits);
    chk("rand_misses", bus.miss_count, m_misses);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
